// File: rtl/multichannel_section_peak_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multichannel_section_peak_pkg
//  Purpose  : Shared level-meter definitions: default section length, sample
//             rate, and the saturating magnitude helper reused by meter blocks.
//  Contents : DEFAULT_SECTION_LEN, SAMPLE_RATE_HZ, sat_abs()
//  Revision : 1.0  initial release
// ============================================================================
package multichannel_section_peak_pkg;

  // 735 samples per section gives 60 updates per second at 44.1 kHz.
  localparam int DEFAULT_SECTION_LEN = 735;
  localparam int SAMPLE_RATE_HZ      = 44100;

  // Magnitude of a two's-complement value of 'width' bits (width <= 32),
  // zero-extended into x. The most-negative value saturates to 2^(width-1)-1
  // so the result always fits in width-1 bits.
  function automatic logic [31:0] sat_abs(input logic [31:0] x, input int width);
    logic [31:0] mask;
    logic [31:0] xm;
    logic [31:0] min_neg;
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    xm      = x & mask;
    min_neg = 32'd1 << (width - 1);
    if ((xm & min_neg) == 32'd0) begin
      return xm;
    end else if (xm == min_neg) begin
      return min_neg - 32'd1;
    end else begin
      return ((~xm) + 32'd1) & mask;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/multichannel_section_peak_if.sv
`default_nettype none
// ============================================================================
//  Module   : multichannel_section_peak_if
//  Purpose  : Sample-in / peak-out stream bundle for the section peak detector.
//  Signals  : i_valid/i_ready/i_channel/i_value  - tagged sample stream
//             o_valid/o_ready/o_channel/o_value  - per-channel peak results
//  Modports : master - stream source and result sink (testbench / upstream)
//             slave  - the peak detector itself
//  Revision : 1.0  initial release
// ============================================================================
interface multichannel_section_peak_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 15,
  parameter int CH_W      = 1
);
  logic                 i_valid;
  logic                 i_ready;
  logic [CH_W-1:0]      i_channel;
  logic [IN_WIDTH-1:0]  i_value;
  logic                 o_valid;
  logic                 o_ready;
  logic [CH_W-1:0]      o_channel;
  logic [OUT_WIDTH-1:0] o_value;

  modport master (
    output i_valid, i_channel, i_value, o_ready,
    input  i_ready, o_valid, o_channel, o_value
  );

  modport slave (
    input  i_valid, i_channel, i_value, o_ready,
    output i_ready, o_valid, o_channel, o_value
  );
endinterface
`default_nettype wire

// File: rtl/multichannel_section_peak_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first set req bit at or after
//             ptr, wrapping at N. The pointer register lives in the parent.
//  Ports    : req   in  N   request flags
//             ptr   in  PW  search start index
//             grant out PW  selected index (0 when none)
//             any   out 1   at least one request set
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any
);

  always_comb begin
    int j;
    grant = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any   = 1'b1;
        grant = PW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multichannel_section_peak.sv
`default_nettype none
// ============================================================================
//  Module   : multichannel_section_peak
//  Purpose  : Per-channel section peak detector. Tracks the peak magnitude of
//             each interleaved channel over SECTION_LEN accepted samples,
//             parks finished peaks in per-channel slots and drains them
//             round-robin through a registered valid/ready output.
//  Ports    : clk    in  1  clock
//             reset  in  1  synchronous active-high reset
//             bus    slave modport of multichannel_section_peak_if
//  Revision : 1.0  initial release
// ============================================================================
module multichannel_section_peak
  import multichannel_section_peak_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int CHANNELS    = 2,
  parameter int SECTION_LEN = DEFAULT_SECTION_LEN,
  parameter int SIGNED_IN   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  multichannel_section_peak_if.slave   bus
);

  localparam int OUT_WIDTH = (SIGNED_IN != 0) ? IN_WIDTH - 1 : IN_WIDTH;
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W     = (SECTION_LEN > 1) ? $clog2(SECTION_LEN) : 1;

  logic [OUT_WIDTH-1:0] acc  [CHANNELS];
  logic [CNT_W-1:0]     cnt  [CHANNELS];
  logic [OUT_WIDTH-1:0] slot [CHANNELS];
  logic [CHANNELS-1:0]  pend;
  logic [CH_W-1:0]      ptr;

  logic                 in_range;
  logic [CH_W-1:0]      idx;
  logic                 is_final;
  logic                 accept;
  logic [31:0]          mag32;
  logic [OUT_WIDTH-1:0] mag;
  logic [OUT_WIDTH-1:0] peak;
  logic [CH_W-1:0]      grant;
  logic                 any;
  logic                 load;

  // Magnitude of the incoming sample, already sized to the result width.
  always_comb begin
    mag32 = 32'(bus.i_value);
    if (SIGNED_IN != 0) mag32 = sat_abs(32'(bus.i_value), IN_WIDTH);
    mag = mag32[OUT_WIDTH-1:0];
  end

  // Out-of-range channel tags are consumed without touching any state; idx is
  // forced to 0 so array lookups stay in bounds.
  assign in_range = int'(bus.i_channel) < CHANNELS;
  assign idx      = in_range ? bus.i_channel : '0;
  assign is_final = (cnt[idx] == CNT_W'(SECTION_LEN - 1));
  assign peak     = (mag > acc[idx]) ? mag : acc[idx];

  // A final sample can only land once its slot is empty. Registered pend is
  // used, so a slot being drained this cycle frees the input next cycle.
  assign bus.i_ready = !(in_range && is_final && pend[idx]);
  assign accept      = bus.i_valid && bus.i_ready;

  assign load = !bus.o_valid || bus.o_ready;

  rr_arbiter #(
    .N  (CHANNELS),
    .PW (CH_W)
  ) u_arb (
    .req   (pend),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c]  <= '0;
        cnt[c]  <= '0;
        slot[c] <= '0;
      end
      pend          <= '0;
      ptr           <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_value   <= '0;
      bus.o_channel <= '0;
    end else begin
      // Output register: pick the next pending slot whenever it is free.
      if (load) begin
        if (any) begin
          bus.o_value   <= slot[grant];
          bus.o_channel <= grant;
          bus.o_valid   <= 1'b1;
          pend[grant]   <= 1'b0;
          ptr           <= (int'(grant) == CHANNELS - 1) ? '0 : grant + CH_W'(1);
        end else begin
          bus.o_valid   <= 1'b0;
        end
      end

      // A final sample is only accepted when pend[idx] is clear, so this
      // set can never collide with the arbiter clearing the same channel.
      if (accept && in_range) begin
        if (is_final) begin
          slot[idx] <= peak;
          pend[idx] <= 1'b1;
          acc[idx]  <= '0;
          cnt[idx]  <= '0;
        end else begin
          acc[idx]  <= peak;
          cnt[idx]  <= cnt[idx] + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multichannel_section_peak.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multichannel_section_peak
//  Purpose  : Directed self-checking bench. Instance a: 3 channels, section
//             length 4, signed 16-bit input. Instance b: 1 channel, section
//             length 1, unsigned 16-bit input.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multichannel_section_peak;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multichannel_section_peak_if #(.IN_WIDTH(16), .OUT_WIDTH(15), .CH_W(2)) a_if ();
  multichannel_section_peak_if #(.IN_WIDTH(16), .OUT_WIDTH(16), .CH_W(1)) b_if ();

  multichannel_section_peak #(
    .IN_WIDTH(16), .CHANNELS(3), .SECTION_LEN(4), .SIGNED_IN(1)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  multichannel_section_peak #(
    .IN_WIDTH(16), .CHANNELS(1), .SECTION_LEN(1), .SIGNED_IN(0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample on instance a and hold it until accepted.
  task automatic send(input logic [1:0] ch, input logic [15:0] v);
    int n;
    n = 0;
    a_if.i_valid   = 1'b1;
    a_if.i_channel = ch;
    a_if.i_value   = v;
    #1;
    while (!a_if.i_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
    tick();
    a_if.i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v0 [4];
    logic [15:0] v1 [4];
    logic [15:0] v2 [4];
    v0 = '{16'd10, 16'd20, 16'd30, 16'd40};
    v1 = '{16'd11, 16'hFFCE, 16'd3, 16'd4};
    v2 = '{16'd7, 16'd7, 16'd7, 16'd7};

    a_if.i_valid = 1'b0; a_if.i_channel = '0; a_if.i_value = '0; a_if.o_ready = 1'b1;
    b_if.i_valid = 1'b0; b_if.i_channel = '0; b_if.i_value = '0; b_if.o_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_o_valid",   32'(a_if.o_valid),   32'd0);
    chk("rst_o_value",   32'(a_if.o_value),   32'd0);
    chk("rst_o_channel", 32'(a_if.o_channel), 32'd0);
    chk("rst_b_o_valid", 32'(b_if.o_valid),   32'd0);
    reset = 1'b0;
    tick();
    chk("rst_i_ready",   32'(a_if.i_ready),   32'd1);

    // Ch0: 5,-9,3,2 -> 9, valid exactly one cycle, one edge after the final
    send(2'd0, 16'd5);
    send(2'd0, 16'hFFF7);
    send(2'd0, 16'd3);
    send(2'd0, 16'd2);
    chk("t1_latency_valid", 32'(a_if.o_valid), 32'd0);
    tick();
    chk("t1_valid",   32'(a_if.o_valid),   32'd1);
    chk("t1_channel", 32'(a_if.o_channel), 32'd0);
    chk("t1_value",   32'(a_if.o_value),   32'd9);
    tick();
    chk("t1_one_cycle", 32'(a_if.o_valid), 32'd0);

    // Ch1: most-negative x4 saturates to 32767
    repeat (4) send(2'd1, 16'h8000);
    tick();
    chk("t2_valid",   32'(a_if.o_valid),   32'd1);
    chk("t2_channel", 32'(a_if.o_channel), 32'd1);
    chk("t2_value",   32'(a_if.o_value),   32'd32767);
    tick();
    // Accumulator restarts at 0: 1,1,1,2 -> 2
    send(2'd1, 16'd1);
    send(2'd1, 16'd1);
    send(2'd1, 16'd1);
    send(2'd1, 16'd2);
    tick();
    chk("t2_restart_value", 32'(a_if.o_value), 32'd2);
    tick();

    // Interleaved finals with o_ready low
    a_if.o_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      send(2'd0, v0[r]);
      send(2'd1, v1[r]);
      send(2'd2, v2[r]);
    end
    tick();
    chk("t3_hold_valid",   32'(a_if.o_valid),   32'd1);
    chk("t3_hold_channel", 32'(a_if.o_channel), 32'd0);
    chk("t3_hold_value",   32'(a_if.o_value),   32'd40);
    // Another ch0 section parks in slot 0, then a third one starts
    send(2'd0, 16'd1);
    send(2'd0, 16'd2);
    send(2'd0, 16'd3);
    send(2'd0, 16'd5);
    send(2'd0, 16'd6);
    send(2'd0, 16'd7);
    send(2'd0, 16'd8);
    chk("t3_stable_value", 32'(a_if.o_value), 32'd40);
    // Final ch0 sample while pend[0] set must stall
    a_if.i_valid = 1'b1; a_if.i_channel = 2'd0; a_if.i_value = 16'd9;
    #1;
    chk("t3_stall_ready", 32'(a_if.i_ready), 32'd0);
    tick();
    tick();
    chk("t3_stall_ready_held", 32'(a_if.i_ready), 32'd0);
    chk("t3_stable_channel",   32'(a_if.o_channel), 32'd0);
    a_if.o_ready = 1'b1;
    tick();
    chk("t3_drain1_channel", 32'(a_if.o_channel), 32'd1);
    chk("t3_drain1_value",   32'(a_if.o_value),   32'd50);
    tick();
    chk("t3_drain2_channel", 32'(a_if.o_channel), 32'd2);
    chk("t3_drain2_value",   32'(a_if.o_value),   32'd7);
    tick();
    chk("t3_drain3_channel", 32'(a_if.o_channel), 32'd0);
    chk("t3_drain3_value",   32'(a_if.o_value),   32'd5);
    chk("t3_unstall_ready",  32'(a_if.i_ready),   32'd1);
    tick();
    a_if.i_valid = 1'b0;
    chk("t3_gap_valid", 32'(a_if.o_valid), 32'd0);
    tick();
    chk("t3_held_valid",   32'(a_if.o_valid),   32'd1);
    chk("t3_held_channel", 32'(a_if.o_channel), 32'd0);
    chk("t3_held_value",   32'(a_if.o_value),   32'd9);
    tick();
    chk("t3_end_valid", 32'(a_if.o_valid), 32'd0);

    // Out-of-range channel is accepted and ignored
    a_if.i_valid = 1'b1; a_if.i_channel = 2'd3; a_if.i_value = 16'd30000;
    #1;
    chk("t4_ready", 32'(a_if.i_ready), 32'd1);
    tick();
    a_if.i_valid = 1'b0;
    repeat (4) send(2'd0, 16'd1);
    tick();
    chk("t4_ch0_value", 32'(a_if.o_value), 32'd1);
    tick();
    repeat (4) send(2'd2, 16'd2);
    tick();
    chk("t4_ch2_channel", 32'(a_if.o_channel), 32'd2);
    chk("t4_ch2_value",   32'(a_if.o_value),   32'd2);
    tick();

    // Reset mid-section discards the partial peak
    send(2'd0, 16'd100);
    send(2'd0, 16'd200);
    reset = 1'b1;
    tick();
    chk("t5_rst_valid",   32'(a_if.o_valid),   32'd0);
    chk("t5_rst_value",   32'(a_if.o_value),   32'd0);
    chk("t5_rst_channel", 32'(a_if.o_channel), 32'd0);
    reset = 1'b0;
    tick();
    send(2'd0, 16'd1);
    send(2'd0, 16'd2);
    send(2'd0, 16'd3);
    send(2'd0, 16'd4);
    tick();
    chk("t5_valid", 32'(a_if.o_valid), 32'd1);
    chk("t5_value", 32'(a_if.o_value), 32'd4);
    tick();

    // Instance b: unsigned, one channel, every sample final
    b_if.i_valid = 1'b1; b_if.i_value = 16'd7;
    tick();
    b_if.i_value = 16'd65535;
    #1;
    chk("t6_second_stall", 32'(b_if.i_ready), 32'd0);
    tick();
    chk("t6_r1_valid", 32'(b_if.o_valid), 32'd1);
    chk("t6_r1_value", 32'(b_if.o_value), 32'd7);
    chk("t6_ready",    32'(b_if.i_ready), 32'd1);
    tick();
    b_if.i_valid = 1'b0;
    chk("t6_gap_valid", 32'(b_if.o_valid), 32'd0);
    tick();
    chk("t6_r2_valid", 32'(b_if.o_valid), 32'd1);
    chk("t6_r2_value", 32'(b_if.o_value), 32'd65535);
    tick();
    chk("t6_end_valid", 32'(b_if.o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
